mem_access_unit: RTL and testbench

- Parametrised load/store unit replacing the single-cycle, combinational memory hookup in stage 3 of the pipelined RV core.
- Registers each load or store and drives a multi-cycle memory bus with an ack handshake, using byte enables, lane alignment and sign/zero extension.
- Holds the pipeline with a stall until the access completes.
- Adds misalignment, bus-error and timeout detection, and load squash on flush.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 81 ++++++++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, func3 encodings, response cause codes and access-size
// helpers for the load/store unit and its lane aligner.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS      = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  // log2 of the access size in bytes; the unsigned-load bit does not change the size
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic store, input int xlen);
    logic ok;
    ok = 1'b1;
    if (f3 == 3'b111)                       ok = 1'b0;
    if (store && f3[2])                     ok = 1'b0;
    if ((f3[1:0] == F3_D[1:0]) && (xlen != 64)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data replication and byte enables on the
// request side, load lane extraction and sign/zero extension on the response side.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int LW = $clog2(XLEN / 8)
) (
  input  logic            req_store,
  input  logic [2:0]      req_func3,
  input  logic [LW-1:0]   req_addr_low,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] st_data,
  output logic [NB-1:0]   st_be,
  output logic            req_bad,
  input  logic [2:0]      ld_func3,
  input  logic [LW-1:0]   ld_addr_low,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [1:0]        req_size;
  logic [1:0]        ld_size;
  logic [LW-1:0]     align_mask;
  logic [XLEN-1:0]   ld_shift;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;
  logic signed [31:0] ld_w;

  assign req_size = f3_size(req_func3);
  assign ld_size  = f3_size(ld_func3);

  always_comb begin
    align_mask = LW'((4'd1 << req_size) - 4'd1);
    req_bad    = !f3_legal(req_func3, req_store, XLEN) || (|(req_addr_low & align_mask));
    st_data    = req_wdata;
    st_be      = '1;
    case (req_size)
      2'd0: begin
        for (int i = 0; i < NB; i++) st_data[8*i +: 8] = req_wdata[7:0];
        st_be = NB'(1) << req_addr_low;
      end
      2'd1: begin
        for (int i = 0; i < NB / 2; i++) st_data[16*i +: 16] = req_wdata[15:0];
        st_be = NB'(3) << req_addr_low;
      end
      2'd2: begin
        for (int i = 0; i < NB / 4; i++) st_data[32*i +: 32] = req_wdata[31:0];
        st_be = NB'(15) << req_addr_low;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from the access width.
  assign ld_shift = ld_rdata >> {ld_addr_low, 3'b000};
  assign ld_b     = ld_shift[7:0];
  assign ld_h     = ld_shift[15:0];
  assign ld_w     = ld_shift[31:0];

  always_comb begin
    ld_data = ld_shift;
    case (ld_size)
      2'd0: begin
        if (ld_func3[2]) ld_data = XLEN'(ld_shift[7:0]);
        else             ld_data = XLEN'(ld_b);
      end
      2'd1: begin
        if (ld_func3[2]) ld_data = XLEN'(ld_shift[15:0]);
        else             ld_data = XLEN'(ld_h);
      end
      2'd2: begin
        if (ld_func3[2]) ld_data = XLEN'(ld_shift[31:0]);
        else             ld_data = XLEN'(ld_w);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Stage-3 load/store unit: registers one access, runs it over an ack-based
// memory bus, stalls the pipeline meanwhile and reports data or an error cause.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                req_valid,
  input  logic                req_store,
  input  logic [2:0]          req_func3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic                flush,
  output logic                stall,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_err,
  output logic [1:0]          resp_cause,
  output logic [ADDR_W-1:0]   MEM_addr,
  output logic [XLEN-1:0]     MEM_WR_out,
  output logic [XLEN/8-1:0]   MEM_be,
  output logic                MEM_rd_en,
  output logic                MEM_wr_en,
  input  logic [XLEN-1:0]     MEM_data,
  input  logic                MEM_ack,
  input  logic                MEM_err
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [1:0]        cause_p0, cause_nx;
  logic [15:0]       cnt;
  logic              drop;

  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        func3_p0;
  logic              store_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [NB-1:0]     be_p0;
  logic [XLEN-1:0]   rdata_p0;

  logic [XLEN-1:0]   st_data;
  logic [NB-1:0]     st_be;
  logic              req_bad;
  logic [XLEN-1:0]   ld_data;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .req_store    (req_store),
    .req_func3    (req_func3),
    .req_addr_low (req_addr[LW-1:0]),
    .req_wdata    (req_wdata),
    .st_data      (st_data),
    .st_be        (st_be),
    .req_bad      (req_bad),
    .ld_func3     (func3_p0),
    .ld_addr_low  (addr_p0[LW-1:0]),
    .ld_rdata     (rdata_p0),
    .ld_data      (ld_data)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cause_p0 <= CAUSE_NONE;
      cnt      <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nx;
      cause_p0 <= cause_nx;
      if (state == S_IDLE)
        cnt <= '0;
      else if ((state == S_WAIT) && (cnt != 16'hFFFF))
        cnt <= cnt + 16'd1;
      // The bus transfer always finishes; only the response is dropped.
      if ((state == S_WAIT) && flush)
        drop <= 1'b1;
      else if ((state == S_DONE) || (state == S_ERR))
        drop <= 1'b0;
    end
  end

  // p0: request capture at accept, read data capture at ack
  always_ff @(posedge CLK) begin
    if ((state == S_IDLE) && req_valid) begin
      addr_p0  <= req_addr;
      func3_p0 <= req_func3;
      store_p0 <= req_store;
      wdata_p0 <= st_data;
      be_p0    <= st_be;
    end
    if ((state == S_WAIT) && MEM_ack)
      rdata_p0 <= MEM_data;
  end

  always_comb begin
    state_nx   = state;
    cause_nx   = cause_p0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    resp_cause = CAUSE_NONE;
    MEM_addr   = '0;
    MEM_WR_out = '0;
    MEM_be     = '0;
    MEM_rd_en  = 1'b0;
    MEM_wr_en  = 1'b0;
    case (state)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (req_bad) begin
            state_nx = S_ERR;
            cause_nx = CAUSE_MISALIGN;
          end else begin
            state_nx = S_WAIT;
            cause_nx = CAUSE_NONE;
          end
        end
      end
      S_WAIT: begin
        stall      = 1'b1;
        MEM_addr   = {addr_p0[ADDR_W-1:LW], {LW{1'b0}}};
        MEM_WR_out = wdata_p0;
        MEM_be     = be_p0;
        MEM_rd_en  = !store_p0;
        MEM_wr_en  = store_p0;
        if (MEM_ack) begin
          if (MEM_err) begin
            state_nx = S_ERR;
            cause_nx = CAUSE_BUS;
          end else begin
            state_nx = S_DONE;
          end
        end else if (cnt == CNT_LAST) begin
          state_nx = S_ERR;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      S_DONE: begin
        resp_valid = !drop;
        if (!drop && !store_p0) resp_data = ld_data;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        resp_valid = !drop;
        resp_err   = !drop;
        if (!drop) resp_cause = cause_p0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (XLEN=32, TIMEOUT=8): directed scenarios followed
// by random accesses, each checked against a byte-level model of the access rules.
module tb_mem_access_unit;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              req_valid, req_store, flush;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              stall, resp_valid, resp_err;
  logic [XLEN-1:0]   resp_data;
  logic [1:0]        resp_cause;
  logic [ADDR_W-1:0] MEM_addr;
  logic [XLEN-1:0]   MEM_WR_out;
  logic [3:0]        MEM_be;
  logic              MEM_rd_en, MEM_wr_en;
  logic [XLEN-1:0]   MEM_data;
  logic              MEM_ack, MEM_err;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_store(req_store), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .resp_cause(resp_cause),
    .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out), .MEM_be(MEM_be),
    .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
    .MEM_data(MEM_data), .MEM_ack(MEM_ack), .MEM_err(MEM_err)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access. ack_after: WAIT cycle carrying MEM_ack (0 = never).
  // flush_cyc: WAIT cycle carrying flush (0 = none).
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_after, input logic merr,
                        input logic [31:0] md, input int flush_cyc);
    int n, off, nb, bus, rd, wr, stalls;
    logic legal, timed_out, buserr, exp_got, exp_err, got, stable, done_flag, r_err;
    logic [1:0]  exp_cause, r_cause;
    logic [3:0]  exp_be, cap_be;
    logic [31:0] exp_wr, exp_data, cap_addr, cap_wr, r_data;

    n   = 1 << f3[1:0];
    off = int'(a[1:0]);
    legal = (f3 != 3'd7) && (f3[1:0] != 2'd3) && !(st && f3[2]) && ((a % n) == 0);
    exp_be = '0;
    exp_wr = '0;
    for (int j = 0; j < 4; j++) begin
      if (j >= off && j < off + n) exp_be[j] = 1'b1;
      exp_wr[8*j +: 8] = wd[8*(j % n) +: 8];
    end
    exp_data = '0;
    for (int i = 0; i < n && off + i < 4; i++) exp_data[8*i +: 8] = md[8*(off+i) +: 8];
    if (!f3[2] && n < 4 && exp_data[8*n-1])
      for (int i = n; i < 4; i++) exp_data[8*i +: 8] = 8'hFF;
    nb        = legal ? ((ack_after > 0) ? ack_after : TIMEOUT) : 0;
    timed_out = legal && (ack_after == 0);
    buserr    = legal && (ack_after > 0) && merr;
    exp_got   = !(legal && flush_cyc > 0 && flush_cyc <= nb);
    exp_err   = !legal || timed_out || buserr;
    exp_cause = !legal ? 2'd1 : timed_out ? 2'd3 : buserr ? 2'd2 : 2'd0;
    if (exp_err || st) exp_data = '0;

    req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(negedge CLK);
    check("stall_on_req", stall, 1'b1);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;

    bus = 0; rd = 0; wr = 0; stalls = 1; got = 0; stable = 1; done_flag = 0;
    r_err = 0; r_cause = 0; r_data = 0; cap_addr = 0; cap_be = 0; cap_wr = 0;
    for (int c = 0; c < 40 && !done_flag; c++) begin
      @(negedge CLK);
      if (MEM_rd_en || MEM_wr_en) begin
        bus++;
        if (MEM_rd_en) rd++;
        if (MEM_wr_en) wr++;
        if (bus == 1) begin
          cap_addr = MEM_addr; cap_be = MEM_be; cap_wr = MEM_WR_out;
        end else if (MEM_addr !== cap_addr || MEM_be !== cap_be || MEM_WR_out !== cap_wr) begin
          stable = 0;
        end
        if (bus == ack_after) begin
          MEM_ack = 1'b1; MEM_err = merr; MEM_data = md;
        end
        if (bus == flush_cyc) flush = 1'b1;
      end
      if (stall) stalls++;
      else begin
        done_flag = 1;
        got = resp_valid; r_data = resp_data; r_err = resp_err; r_cause = resp_cause;
      end
      @(posedge CLK); #1;
      MEM_ack = 1'b0; MEM_err = 1'b0; flush = 1'b0; MEM_data = $urandom;
    end

    check("access_completes", done_flag, 1'b1);
    check("rd_en_cycles", rd, st ? 0 : nb);
    check("wr_en_cycles", wr, st ? nb : 0);
    check("stall_cycles", stalls, 1 + nb);
    check("resp_valid_seen", got, exp_got);
    if (nb > 0) begin
      check("mem_addr", cap_addr, a & 32'hFFFF_FFFC);
      check("mem_be", cap_be, exp_be);
      check("bus_stable", stable, 1'b1);
      if (st) check("mem_wr_data", cap_wr, exp_wr);
    end
    if (exp_got) begin
      check("resp_err", r_err, exp_err);
      check("resp_cause", r_cause, exp_cause);
      check("resp_data", r_data, exp_data);
    end
  endtask

  initial begin
    Reset = 1'b0; req_valid = 0; req_store = 0; req_func3 = 0; req_addr = 0;
    req_wdata = 0; flush = 0; MEM_data = 0; MEM_ack = 0; MEM_err = 0;

    // Reset state
    #12;
    check("rst_stall", stall, 1'b0);
    check("rst_resp", {resp_valid, resp_err, resp_cause}, 4'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_en", {MEM_rd_en, MEM_wr_en}, 2'd0);
    check("rst_mem_bus", {MEM_addr, MEM_be, MEM_WR_out}, 68'd0);
    @(posedge CLK); #1 Reset = 1'b1;
    @(posedge CLK); #1;

    // Directed scenarios
    access(1'b0, 3'b010, 32'h100, 32'h0, 4, 1'b0, 32'hDEADBEEF, 0);   // LW
    access(1'b0, 3'b000, 32'h103, 32'h0, 2, 1'b0, 32'h80FFFFFF, 0);   // LB
    access(1'b0, 3'b100, 32'h103, 32'h0, 2, 1'b0, 32'h80FFFFFF, 0);   // LBU
    access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1, 1'b0, 32'h0, 0);   // SH
    access(1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b0, 32'h0, 0);          // misaligned LW
    access(1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b0, 32'h0, 0);          // LD on RV32
    access(1'b0, 3'b010, 32'h104, 32'h0, 0, 1'b0, 32'h0, 0);          // timeout
    access(1'b1, 3'b010, 32'h108, 32'h55AA55AA, 3, 1'b1, 32'h0, 0);   // bus error
    access(1'b0, 3'b001, 32'h10A, 32'h0, 3, 1'b0, 32'h0000F00D, 2);   // flushed load
    access(1'b0, 3'b101, 32'h10A, 32'h0, 1, 1'b0, 32'h8001F00D, 0);   // LHU after flush

    // Ack outside WAIT has no effect
    MEM_ack = 1'b1;
    @(negedge CLK);
    check("idle_ack_ignored", {resp_valid, MEM_rd_en, MEM_wr_en}, 3'd0);
    @(posedge CLK); #1 MEM_ack = 1'b0;

    // Asynchronous reset in the middle of WAIT
    req_valid = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h200;
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    check("pre_reset_rd_en", MEM_rd_en, 1'b1);
    #1 Reset = 1'b0;
    #1;
    check("async_reset_rd_en", MEM_rd_en, 1'b0);
    check("async_reset_stall", stall, 1'b0);
    @(posedge CLK); #1 Reset = 1'b1;
    @(posedge CLK); #1;
    access(1'b0, 3'b010, 32'h204, 32'h0, 1, 1'b0, 32'hCAFEF00D, 0);

    // Random accesses
    for (int k = 0; k < 40; k++) begin
      logic st, merr;
      logic [2:0] f3;
      int ack, nbw, fl;
      st   = 1'($urandom_range(0, 1));
      f3   = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      ack  = $urandom_range(0, TIMEOUT);
      merr = ($urandom_range(0, 4) == 0);
      nbw  = (ack > 0) ? ack : TIMEOUT;
      fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nbw) : 0;
      access(st, f3, 32'h1000 + 32'($urandom_range(0, 255)), $urandom, ack, merr, $urandom, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
